alu_decoder: RTL and testbench

ALU_DECODER -- requirements
Module: alu_decoder

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_dec_comb.sv | 99 +++++++++
 rtl/alu_decoder.sv | 101 ++++++++++
 tb/tb_alu_decoder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Shared ALUSel codes, opcode/funct constants and decode payload.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int C_XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRA  = 4'd6,
        ALU_SRL  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alusel_e;

    localparam logic [6:0] C_OPC_OP     = 7'b0110011;
    localparam logic [6:0] C_OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] C_OPC_LUI    = 7'b0110111;
    localparam logic [6:0] C_OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] C_F3_ADD  = 3'b000;
    localparam logic [2:0] C_F3_SLL  = 3'b001;
    localparam logic [2:0] C_F3_SLT  = 3'b010;
    localparam logic [2:0] C_F3_SLTU = 3'b011;
    localparam logic [2:0] C_F3_XOR  = 3'b100;
    localparam logic [2:0] C_F3_SR   = 3'b101;
    localparam logic [2:0] C_F3_OR   = 3'b110;
    localparam logic [2:0] C_F3_AND  = 3'b111;

    localparam logic [6:0] C_F7_BASE = 7'b0000000;
    localparam logic [6:0] C_F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [C_XLEN-1:0] a;
        logic [C_XLEN-1:0] b;
        alusel_e           alusel;
        logic [4:0]        rd;
        logic              illegal;
    } dec_payload_t;

    function automatic logic [C_XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(C_XLEN-12){imm[11]}}, imm};
    endfunction

    // ALT selects the subtract / arithmetic-shift variant of funct3 000 / 101.
    function automatic alusel_e f3_to_sel(input logic [2:0] f3, input logic alt);
        alusel_e sel;
        case (f3)
            C_F3_ADD:  sel = alt ? ALU_SUB : ALU_ADD;
            C_F3_SLL:  sel = ALU_SLL;
            C_F3_SLT:  sel = ALU_SLT;
            C_F3_SLTU: sel = ALU_SLTU;
            C_F3_XOR:  sel = ALU_XOR;
            C_F3_SR:   sel = alt ? ALU_SRA : ALU_SRL;
            C_F3_OR:   sel = ALU_OR;
            default:   sel = ALU_AND;
        endcase
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dec_comb.sv
`default_nettype none
// ============================================================================
// Module   : alu_dec_comb
// Brief    : Combinational R/I-type decode into ALU operands and ALUSel.
//            Optional LUI/AUIPC decode enabled by macro ALU_DEC_UIMM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_dec_comb
    import alu_pkg::*;
(
    input  logic [31:0]       i_instr,
    input  logic [C_XLEN-1:0] i_pc,
    input  logic [C_XLEN-1:0] i_rs1,
    input  logic [C_XLEN-1:0] i_rs2,
    output dec_payload_t      o_dec
);

    logic [6:0]        w_opcode;
    logic [2:0]        w_funct3;
    logic [6:0]        w_funct7;
    logic              w_legal;
    logic              w_is_shift;
    logic [C_XLEN-1:0] w_a;
    logic [C_XLEN-1:0] w_b;
    alusel_e           w_sel;

    assign w_opcode   = i_instr[6:0];
    assign w_funct3   = i_instr[14:12];
    assign w_funct7   = i_instr[31:25];
    assign w_is_shift = (w_funct3 == C_F3_SLL) || (w_funct3 == C_F3_SR);

    // Register-number fields are resolved upstream; rs1 index is never needed here.
    logic w_unused_rs1_idx;
    assign w_unused_rs1_idx = ^i_instr[19:15];

`ifndef ALU_DEC_UIMM_EN
    logic w_unused_pc;
    assign w_unused_pc = ^i_pc;
`endif

    always_comb begin
        w_legal = 1'b0;
        w_a     = '0;
        w_b     = '0;
        w_sel   = ALU_ADD;
        case (w_opcode)
            C_OPC_OP: begin
                w_a     = i_rs1;
                w_b     = i_rs2;
                w_sel   = f3_to_sel(w_funct3, w_funct7 == C_F7_ALT);
                w_legal = (w_funct7 == C_F7_BASE) ||
                          ((w_funct7 == C_F7_ALT) &&
                           ((w_funct3 == C_F3_ADD) || (w_funct3 == C_F3_SR)));
            end
            C_OPC_OP_IMM: begin
                w_a   = i_rs1;
                w_b   = w_is_shift ? {27'b0, i_instr[24:20]} : sext12(i_instr[31:20]);
                w_sel = f3_to_sel(w_funct3,
                                  (w_funct3 == C_F3_SR) && (w_funct7 == C_F7_ALT));
                if (w_funct3 == C_F3_SLL) begin
                    w_legal = (w_funct7 == C_F7_BASE);
                end else if (w_funct3 == C_F3_SR) begin
                    w_legal = (w_funct7 == C_F7_BASE) || (w_funct7 == C_F7_ALT);
                end else begin
                    w_legal = 1'b1;
                end
            end
`ifdef ALU_DEC_UIMM_EN
            C_OPC_LUI: begin
                w_a     = '0;
                w_b     = {i_instr[31:12], 12'b0};
                w_sel   = ALU_ADD;
                w_legal = 1'b1;
            end
            C_OPC_AUIPC: begin
                w_a     = i_pc;
                w_b     = {i_instr[31:12], 12'b0};
                w_sel   = ALU_ADD;
                w_legal = 1'b1;
            end
`endif
            default: w_legal = 1'b0;
        endcase
    end

    // Illegal entries carry only rd and the flag so the ALU sees a benign ADD 0,0.
    always_comb begin
        o_dec         = '0;
        o_dec.rd      = i_instr[11:7];
        o_dec.illegal = ~w_legal;
        if (w_legal) begin
            o_dec.a      = w_a;
            o_dec.b      = w_b;
            o_dec.alusel = w_sel;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : alu_decoder
// Brief    : Decoder front-end with 2-entry skid buffer toward the ALU.
//            Macro ALU_DEC_UIMM_EN enables LUI/AUIPC decode.
// Revision : 1.0 - initial release
// ============================================================================
module alu_decoder
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [3:0]      out_alusel,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    skid_state_e  state_q, state_d;
    dec_payload_t out_q,   out_d;
    dec_payload_t skid_q,  skid_d;
    dec_payload_t w_dec;
    logic         w_in_fire;
    logic         w_out_fire;

    alu_dec_comb u_dec (
        .i_instr (in_instr),
        .i_pc    (in_pc),
        .i_rs1   (in_rs1),
        .i_rs2   (in_rs2),
        .o_dec   (w_dec)
    );

    assign in_ready   = (state_q != ST_SKID) && !reset;
    assign out_valid  = (state_q != ST_EMPTY);
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
        end
    end

    // The output register always holds the oldest entry; skid holds the younger one.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (w_in_fire) begin
                    out_d   = w_dec;
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                if (w_in_fire && w_out_fire) begin
                    out_d = w_dec;
                end else if (w_in_fire) begin
                    skid_d  = w_dec;
                    state_d = ST_SKID;
                end else if (w_out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (w_out_fire) begin
                    out_d   = skid_q;
                    state_d = ST_FULL;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_alusel  = out_q.alusel;
    assign out_rd      = out_q.rd;
    assign out_illegal = out_q.illegal;

endmodule
`default_nettype wire

// File: tb/tb_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_decoder
// Brief    : Directed self-checking bench for alu_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = 32'h0000_1000;
    logic [31:0] in_rs1 = '0;
    logic [31:0] in_rs2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_a;
    logic [31:0] out_b;
    logic [3:0]  out_alusel;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [4:0]  rd;
        logic        ill;
    } vec_t;

    vec_t vq[$];
    vec_t va, vb, vc;

    alu_decoder #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1      (in_rs1),
        .in_rs2      (in_rs2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_alusel  (out_alusel),
        .out_rd      (out_rd),
        .out_illegal (out_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic mkvec(output vec_t v, input logic [31:0] instr, rs1, rs2, a, b,
                         input logic [3:0] sel, input logic [4:0] rd, input logic ill);
        v.instr = instr; v.rs1 = rs1; v.rs2 = rs2;
        v.a = a; v.b = b; v.sel = sel; v.rd = rd; v.ill = ill;
    endtask

    task automatic add(input logic [31:0] instr, rs1, rs2, a, b,
                       input logic [3:0] sel, input logic [4:0] rd, input logic ill);
        vec_t v;
        mkvec(v, instr, rs1, rs2, a, b, sel, rd, ill);
        vq.push_back(v);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_instr = v.instr;
        in_rs1   = v.rs1;
        in_rs2   = v.rs2;
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        check({tag, ".valid"},   32'(out_valid),   32'd1);
        check({tag, ".a"},       out_a,            v.a);
        check({tag, ".b"},       out_b,            v.b);
        check({tag, ".alusel"},  32'(out_alusel),  32'(v.sel));
        check({tag, ".rd"},      32'(out_rd),      32'(v.rd));
        check({tag, ".illegal"}, 32'(out_illegal), 32'(v.ill));
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".valid"},   32'(out_valid),   32'd0);
        check({tag, ".a"},       out_a,            32'd0);
        check({tag, ".b"},       out_b,            32'd0);
        check({tag, ".alusel"},  32'(out_alusel),  32'd0);
        check({tag, ".rd"},      32'(out_rd),      32'd0);
        check({tag, ".illegal"}, 32'(out_illegal), 32'd0);
    endtask

    initial begin
        // instr, rs1, rs2 -> a, b, alusel, rd, illegal
        add(32'h002081B3, 32'd5, 32'd3, 32'd5, 32'd3, 4'd0, 5'd3, 1'b0);
        add(32'h402081B3, 32'd9, 32'd4, 32'd9, 32'd4, 4'd1, 5'd3, 1'b0);
        add(32'h40435293, 32'h80000000, 32'd7, 32'h80000000, 32'd4, 4'd6, 5'd5, 1'b0);
        add(32'hFFF00093, 32'h11, 32'h22, 32'h11, 32'hFFFFFFFF, 4'd0, 5'd1, 1'b0);
        add(32'h022081B3, 32'd1, 32'd2, 32'd0, 32'd0, 4'd0, 5'd3, 1'b1);
        add(32'h002091B3, 32'd1, 32'd2, 32'd1, 32'd2, 4'd2, 5'd3, 1'b0);
        add(32'h0020A1B3, 32'd3, 32'd4, 32'd3, 32'd4, 4'd3, 5'd3, 1'b0);
        add(32'h0020B1B3, 32'd3, 32'd4, 32'd3, 32'd4, 4'd4, 5'd3, 1'b0);
        add(32'h0020C1B3, 32'd6, 32'd7, 32'd6, 32'd7, 4'd5, 5'd3, 1'b0);
        add(32'h0020D1B3, 32'd8, 32'd9, 32'd8, 32'd9, 4'd7, 5'd3, 1'b0);
        add(32'h0020E1B3, 32'd10, 32'd11, 32'd10, 32'd11, 4'd8, 5'd3, 1'b0);
        add(32'h0020F1B3, 32'd12, 32'd13, 32'd12, 32'd13, 4'd9, 5'd3, 1'b0);
        add(32'h4020F1B3, 32'd12, 32'd13, 32'd0, 32'd0, 4'd0, 5'd3, 1'b1);
        add(32'h40409293, 32'd1, 32'd2, 32'd0, 32'd0, 4'd0, 5'd5, 1'b1);
        add(32'h0F00F193, 32'hFF, 32'd2, 32'hFF, 32'hF0, 4'd9, 5'd3, 1'b0);
        add(32'h00000000, 32'd1, 32'd2, 32'd0, 32'd0, 4'd0, 5'd0, 1'b1);
        add(32'h00435293, 32'h80000000, 32'd7, 32'h80000000, 32'd4, 4'd7, 5'd5, 1'b0);
        add(32'h8000A193, 32'd1, 32'd2, 32'd1, 32'hFFFFF800, 4'd3, 5'd3, 1'b0);
`ifdef ALU_DEC_UIMM_EN
        add(32'h123450B7, 32'hAAAA, 32'd2, 32'd0, 32'h12345000, 4'd0, 5'd1, 1'b0);
        add(32'h12345097, 32'hAAAA, 32'd2, 32'h1000, 32'h12345000, 4'd0, 5'd1, 1'b0);
`else
        add(32'h123450B7, 32'hAAAA, 32'd2, 32'd0, 32'd0, 4'd0, 5'd1, 1'b1);
        add(32'h12345097, 32'hAAAA, 32'd2, 32'd0, 32'd0, 4'd0, 5'd1, 1'b1);
`endif

        // Reset state
        #1 reset = 1'b1;
        #2;
        check("rst.in_ready", 32'(in_ready), 32'd0);
        check_zero("rst");
        #9 reset = 1'b0;
        #1;
        check("rst_release.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("idle.out_valid", 32'(out_valid), 32'd0);

        // Streaming at one entry per cycle
        out_ready = 1'b1;
        for (int i = 0; i <= vq.size(); i++) begin
            @(negedge clk);
            if (i > 0) check_vec($sformatf("stream%0d", i - 1), vq[i - 1]);
            check($sformatf("stream%0d.in_ready", i), 32'(in_ready), 32'd1);
            if (i < vq.size()) drive(vq[i]);
            else in_valid = 1'b0;
        end
        @(negedge clk);
        check("stream_end.out_valid", 32'(out_valid), 32'd0);

        // Skid buffer: three offers with downstream stalled
        mkvec(va, 32'h002081B3, 32'd5, 32'd3, 32'd5, 32'd3, 4'd0, 5'd3, 1'b0);
        mkvec(vb, 32'h0020C1B3, 32'hF0F0, 32'h0FF0, 32'hF0F0, 32'h0FF0, 4'd5, 5'd3, 1'b0);
        mkvec(vc, 32'h0020E1B3, 32'h1, 32'h2, 32'h1, 32'h2, 4'd8, 5'd3, 1'b0);
        out_ready = 1'b0;
        drive(va);
        @(negedge clk);
        check_vec("skid.full", va);
        check("skid.full.in_ready", 32'(in_ready), 32'd1);
        drive(vb);
        @(negedge clk);
        check_vec("skid.skid1", va);
        check("skid.skid1.in_ready", 32'(in_ready), 32'd0);
        drive(vc);
        @(negedge clk);
        check_vec("skid.skid2", va);
        check("skid.skid2.in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_vec("skid.drain_b", vb);
        check("skid.drain_b.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("skid.drained.out_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset while in SKID discards both entries
        out_ready = 1'b0;
        drive(va);
        @(negedge clk);
        drive(vb);
        @(negedge clk);
        in_valid = 1'b0;
        check("rst_skid.pre.in_ready", 32'(in_ready), 32'd0);
        #2 reset = 1'b1;
        #1;
        check_zero("rst_skid");
        check("rst_skid.in_ready", 32'(in_ready), 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_skid.after.in_ready", 32'(in_ready), 32'd1);
        check("rst_skid.after.out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        drive(vc);
        @(negedge clk);
        in_valid = 1'b0;
        check_vec("rst_skid.new", vc);
        @(negedge clk);
        check("rst_skid.empty.out_valid", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
